// File: rtl/uart_rx_writer.sv
// uart_rx_writer
//   Receives 8N1 serial frames (8E1 when UART_RX_PARITY_EN is defined) and
//   pushes each good byte into a downstream FIFO with a one-cycle write strobe.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> PARITY state and even-parity checking, 11-bit frames
//   undefined -> 10-bit frames, parity_err tied to 0
//
// Ports
//   clk_w      in   write-side clock (shared with FIFO write port)
//   rst        in   asynchronous active-high reset
//   rx         in   asynchronous serial line, idle high, LSB first
//   fifo_full  in   downstream FIFO full flag
//   clr_err    in   synchronous clear of the sticky error flags
//   wr_en      out  single-cycle FIFO write strobe
//   buff_in    out  received byte, valid while wr_en=1, holds last written byte
//   busy       out  high whenever the FSM is not IDLE
//   frame_err  out  sticky: stop bit sampled 0
//   overrun    out  sticky: good byte dropped because fifo_full=1
//   parity_err out  sticky: parity mismatch
module uart_rx_writer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_w,
    input  logic       rst,
    input  logic       rx,
    input  logic       fifo_full,
    input  logic       clr_err,
    output logic       wr_en,
    output logic [7:0] buff_in,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WRITE
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_s_q, rx_prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      buff_q, buff_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            wr_en_c;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            parity_err_q, parity_err_d;
`endif

    // Synchronizer plus one extra stage for falling-edge detection; all
    // reset high so a line idling high never looks like a start edge.
    always_ff @(posedge clk_w or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk_w or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            buff_q       <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            buff_q       <= buff_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        buff_d      = buff_q;
        wr_en_c     = 1'b0;
        // Clear first so a set event later in this block takes priority.
        frame_err_d = clr_err ? 1'b0 : frame_err_q;
        overrun_d   = clr_err ? 1'b0 : overrun_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = clr_err ? 1'b0 : parity_err_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START;
                    bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end

            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rx_s_q;
                    bit_d          = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    par_bad_d = (^shift_q) != rx_s_q;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = IDLE;
`endif
                    end else begin
                        state_d = WRITE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WRITE: begin
                state_d = IDLE;
                if (fifo_full) begin
                    overrun_d = 1'b1;
                end else begin
                    wr_en_c = 1'b1;
                    buff_d  = shift_q;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Byte is presented combinationally in the WRITE cycle and then latched,
    // so buff_in is valid with the strobe and holds the last written byte.
    assign wr_en     = wr_en_c;
    assign buff_in   = wr_en_c ? shift_q : buff_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
